// File: rtl/vg_pkg.sv
// Shared definitions for the vector-generator state sequencer:
// FSM encoding, microstep strobe indices, PROM and counter widths,
// and a small helper that decodes a microstate against a strobe index.
package vg_pkg;

    // Sequencer FSM encoding
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FETCH = 3'd1,
        ST_WAIT  = 3'd2,
        ST_EXEC  = 3'd3,
        ST_TWAIT = 3'd4,
        ST_PACE  = 3'd5
    } vg_fsm_t;

    // State PROM geometry: address is {opcode, microstate}
    localparam int OP_W     = 4;
    localparam int USTATE_W = 4;
    localparam int ROM_AW   = OP_W + USTATE_W;
    localparam int ROM_DW   = USTATE_W;

    // Strobe/counter widths
    localparam int LATCH_N  = 4;
    localparam int PACE_W   = 8;
    localparam int WDOG_W   = 16;

    // Strobe index carried in microstate bits [2:0] when bit [3] is set
    localparam logic [2:0] STB_LATCH0 = 3'd0;
    localparam logic [2:0] STB_LATCH1 = 3'd1;
    localparam logic [2:0] STB_LATCH2 = 3'd2;
    localparam logic [2:0] STB_LATCH3 = 3'd3;
    localparam logic [2:0] STB_PC_INC = 3'd4;
    localparam logic [2:0] STB_DVY_GO = 3'd5;
    localparam logic [2:0] STB_HALT   = 3'd6;
    localparam logic [2:0] STB_NOP    = 3'd7;

    // True when a microstate requests the strobe selected by idx
    function automatic logic step_hits(input logic [USTATE_W-1:0] step,
                                       input logic [2:0]          idx);
        return step[USTATE_W-1] && (step[2:0] == idx);
    endfunction

endpackage

// File: rtl/vg_step_pacer.sv
// Inter-microstep pacing counter. Loaded with STEP_DIV-1 on entry to the
// pacing state, counts down while enabled, and flags done on the last
// pacing cycle so the sequencer can return to FETCH.
module vg_step_pacer
    import vg_pkg::*;
#(
    parameter int STEP_DIV = 1
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic load,
    input  logic en,
    output logic done
);

    localparam logic [PACE_W-1:0] LOAD_VAL = PACE_W'(STEP_DIV - 1);

    logic [PACE_W-1:0] cnt_reg;
    logic [PACE_W-1:0] cnt_next;

    // Last pacing cycle is the one that sees a count of one (or less)
    assign done = en && (cnt_reg <= PACE_W'(1));

    // Counter next value: clear wins, then load, then count down
    always_comb begin
        cnt_next = cnt_reg;
        if (clr) begin
            cnt_next = '0;
        end else if (load) begin
            cnt_next = LOAD_VAL;
        end else if (en && (cnt_reg != '0)) begin
            cnt_next = cnt_reg - PACE_W'(1);
        end
    end

    // Counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_reg <= '0;
        end else begin
            cnt_reg <= cnt_next;
        end
    end

endmodule

// File: rtl/vg_state_seq.sv
// Vector generator state sequencer. Walks a microcode PROM addressed by
// {opcode, microstate}; each microstep is FETCH -> WAIT -> EXEC, optionally
// followed by a timer wait (TWAIT) and/or pacing (PACE). EXEC fires at most
// one registered strobe chosen by the loaded microstate.
// Optional feature: define VG_WATCHDOG_EN to abort a TWAIT that lasts
// WDOG_CYCLES cycles back to IDLE.
module vg_state_seq
    import vg_pkg::*;
#(
    parameter int STEP_DIV    = 1,
    parameter int WDOG_CYCLES = 4096
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                go,
    input  logic                vgrst,
    input  logic [OP_W-1:0]     dat_op,
    input  logic                timer_done,
    output logic [ROM_AW-1:0]   rom_addr,
    output logic                rom_cs,
    input  logic [ROM_DW-1:0]   rom_dout,
    output logic [LATCH_N-1:0]  latch,
    output logic                pc_inc,
    output logic                dvy_go,
    output logic                halt,
    output logic [USTATE_W-1:0] state
);

    localparam logic PACE_EN = (STEP_DIV > 1);

    vg_fsm_t fsm_reg, fsm_next;

    logic [USTATE_W-1:0] ustate_reg, ustate_next;
    logic [OP_W-1:0]     op_reg, op_next;
    logic [USTATE_W-1:0] addr_lo_reg, addr_lo_next;
    logic [LATCH_N-1:0]  latch_reg, latch_next;
    logic                pc_inc_reg, pc_inc_next;
    logic                dvy_go_reg, dvy_go_next;
    logic                halt_reg, halt_next;
    logic                rom_cs_reg, rom_cs_next;

    logic [LATCH_N-1:0]  wait_latch;
    logic                exec_halt;
    logic                exec_dvy;
    logic                pace_done;
    logic                pace_load;
    logic                wdog_expire;

    // Latch strobe requests decoded from the PROM word arriving in WAIT
    generate
        for (genvar gi = 0; gi < LATCH_N; gi++) begin : g_latch
            assign wait_latch[gi] = step_hits(rom_dout, STB_LATCH0 + 3'(gi));
        end
    endgenerate

    assign exec_halt = step_hits(ustate_reg, STB_HALT);
    assign exec_dvy  = step_hits(ustate_reg, STB_DVY_GO);

    // PROM address is live only in FETCH; otherwise it holds the last fetch
    assign rom_addr = (fsm_reg == ST_FETCH) ? {dat_op, ustate_reg}
                                            : {op_reg, addr_lo_reg};

    assign rom_cs = rom_cs_reg;
    assign latch  = latch_reg;
    assign pc_inc = pc_inc_reg;
    assign dvy_go = dvy_go_reg;
    assign halt   = halt_reg;
    assign state  = ustate_reg;

`ifdef VG_WATCHDOG_EN
    localparam logic [WDOG_W-1:0] WDOG_LAST = WDOG_W'(WDOG_CYCLES - 1);

    logic [WDOG_W-1:0] wdog_cnt_reg, wdog_cnt_next;

    // A timer completion on the final cycle still takes precedence
    assign wdog_expire = (fsm_reg == ST_TWAIT) && !timer_done &&
                         (wdog_cnt_reg == WDOG_LAST);

    // Watchdog counts TWAIT cycles and restarts on every other state
    always_comb begin
        wdog_cnt_next = '0;
        if ((fsm_reg == ST_TWAIT) && !vgrst) begin
            wdog_cnt_next = wdog_cnt_reg + WDOG_W'(1);
        end
    end

    // Watchdog counter register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_cnt_reg <= '0;
        end else begin
            wdog_cnt_reg <= wdog_cnt_next;
        end
    end
`else
    // Without the watchdog TWAIT only ends on timer_done; the limit is
    // folded into a constant so the parameter stays part of the interface.
    localparam logic WDOG_NEVER = (WDOG_CYCLES < 0);
    assign wdog_expire = WDOG_NEVER;
`endif

    assign pace_load = (fsm_next == ST_PACE) && (fsm_reg != ST_PACE);

    vg_step_pacer #(
        .STEP_DIV (STEP_DIV)
    ) u_pacer (
        .clk   (clk),
        .reset (reset),
        .clr   (vgrst),
        .load  (pace_load),
        .en    (fsm_reg == ST_PACE),
        .done  (pace_done)
    );

    // FSM state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fsm_reg <= ST_IDLE;
        end else begin
            fsm_reg <= fsm_next;
        end
    end

    // FSM next-state logic; soft reset overrides every transition
    always_comb begin
        fsm_next = fsm_reg;
        case (fsm_reg)
            ST_IDLE: begin
                if (go) begin
                    fsm_next = ST_FETCH;
                end
            end
            ST_FETCH: fsm_next = ST_WAIT;
            ST_WAIT:  fsm_next = ST_EXEC;
            ST_EXEC: begin
                if (exec_halt) begin
                    fsm_next = ST_IDLE;
                end else if (exec_dvy) begin
                    fsm_next = ST_TWAIT;
                end else if (PACE_EN) begin
                    fsm_next = ST_PACE;
                end else begin
                    fsm_next = ST_FETCH;
                end
            end
            ST_TWAIT: begin
                if (timer_done) begin
                    fsm_next = PACE_EN ? ST_PACE : ST_FETCH;
                end else if (wdog_expire) begin
                    fsm_next = ST_IDLE;
                end
            end
            ST_PACE: begin
                if (pace_done) begin
                    fsm_next = ST_FETCH;
                end
            end
            default: fsm_next = ST_IDLE;
        endcase
        if (vgrst) begin
            fsm_next = ST_IDLE;
        end
    end

    // Output/datapath next values; strobes are prepared in WAIT so they
    // come straight out of flops during EXEC
    always_comb begin
        ustate_next  = ustate_reg;
        op_next      = op_reg;
        addr_lo_next = addr_lo_reg;
        latch_next   = '0;
        pc_inc_next  = 1'b0;
        dvy_go_next  = 1'b0;
        case (fsm_reg)
            ST_IDLE: begin
                if (go) begin
                    ustate_next = '0;
                end
            end
            ST_FETCH: begin
                op_next      = dat_op;
                addr_lo_next = ustate_reg;
            end
            ST_WAIT: begin
                ustate_next = rom_dout;
                latch_next  = wait_latch;
                pc_inc_next = step_hits(rom_dout, STB_PC_INC);
                dvy_go_next = step_hits(rom_dout, STB_DVY_GO);
            end
            default: ;
        endcase
        if (wdog_expire) begin
            ustate_next = '0;
        end
        if (vgrst) begin
            ustate_next = '0;
            latch_next  = '0;
            pc_inc_next = 1'b0;
            dvy_go_next = 1'b0;
        end
        halt_next   = (fsm_next == ST_IDLE);
        rom_cs_next = (fsm_next == ST_FETCH);
    end

    // Datapath and registered output flops
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ustate_reg  <= '0;
            op_reg      <= '0;
            addr_lo_reg <= '0;
            latch_reg   <= '0;
            pc_inc_reg  <= 1'b0;
            dvy_go_reg  <= 1'b0;
            halt_reg    <= 1'b1;
            rom_cs_reg  <= 1'b0;
        end else begin
            ustate_reg  <= ustate_next;
            op_reg      <= op_next;
            addr_lo_reg <= addr_lo_next;
            latch_reg   <= latch_next;
            pc_inc_reg  <= pc_inc_next;
            dvy_go_reg  <= dvy_go_next;
            halt_reg    <= halt_next;
            rom_cs_reg  <= rom_cs_next;
        end
    end

endmodule

// File: tb/tb_vg_state_seq.sv
// Testbench for vg_state_seq: directed microcode programs in a registered
// PROM model, strobe scoreboards per instance, plus direct level checks.
// dut runs STEP_DIV=1 / WDOG_CYCLES=16, dut4 runs STEP_DIV=4.
module tb_vg_state_seq;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       go = 1'b0, vgrst = 1'b0, timer_done = 1'b0;
    logic       go4 = 1'b0, vgrst4 = 1'b0;
    logic [3:0] dat_op = 4'h0;

    logic [7:0] rom_addr, rom_addr4;
    logic       rom_cs, rom_cs4;
    logic [3:0] rom_dout = 4'h0, rom_dout4 = 4'h0;
    logic [3:0] latch, latch4;
    logic       pc_inc, pc_inc4, dvy_go, dvy_go4, halt, halt4;
    logic [3:0] state, state4;

    logic [3:0] rom_mem [256];

    typedef struct packed {
        int         c;
        logic [3:0] lt;
        logic       pc;
        logic       dv;
        logic [3:0] st;
    } exp_t;

    exp_t sb[$];
    exp_t sb4[$];
    exp_t mon_e, mon_e4;

    int cyc = 0;
    int checks = 0;
    int passes = 0;

    vg_state_seq #(.STEP_DIV(1), .WDOG_CYCLES(16)) dut (
        .clk(clk), .reset(reset), .go(go), .vgrst(vgrst), .dat_op(dat_op),
        .timer_done(timer_done), .rom_addr(rom_addr), .rom_cs(rom_cs),
        .rom_dout(rom_dout), .latch(latch), .pc_inc(pc_inc), .dvy_go(dvy_go),
        .halt(halt), .state(state)
    );

    vg_state_seq #(.STEP_DIV(4), .WDOG_CYCLES(16)) dut4 (
        .clk(clk), .reset(reset), .go(go4), .vgrst(vgrst4), .dat_op(dat_op),
        .timer_done(1'b0), .rom_addr(rom_addr4), .rom_cs(rom_cs4),
        .rom_dout(rom_dout4), .latch(latch4), .pc_inc(pc_inc4), .dvy_go(dvy_go4),
        .halt(halt4), .state(state4)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Registered PROM model, read only while selected
    always @(posedge clk) begin
        if (rom_cs)  rom_dout  <= rom_mem[rom_addr];
        if (rom_cs4) rom_dout4 <= rom_mem[rom_addr4];
    end

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act == exp) passes++;
        else $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic expect_stb(input int unit, input int c, input logic [3:0] lt,
                              input logic pc, input logic dv, input logic [3:0] st);
        exp_t e;
        e.c = c; e.lt = lt; e.pc = pc; e.dv = dv; e.st = st;
        if (unit == 0) sb.push_back(e);
        else sb4.push_back(e);
    endtask

    task automatic to_cyc(input int k);
        while (cyc < k) @(negedge clk);
    endtask

    // Monitor for dut strobes
    always @(negedge clk) begin
        if (latch != 4'b0 || pc_inc || dvy_go) begin
            checks++;
            if (sb.size() == 0) begin
                $display("FAIL dut_unexpected_strobe: cyc=%0d latch=%b pc_inc=%b dvy_go=%b state=%h, required none",
                         cyc, latch, pc_inc, dvy_go, state);
            end else begin
                mon_e = sb.pop_front();
                if (mon_e.c == cyc && mon_e.lt == latch && mon_e.pc == pc_inc &&
                    mon_e.dv == dvy_go && mon_e.st == state) begin
                    passes++;
                    $display("dut  strobe cyc=%0d latch=%b pc_inc=%b dvy_go=%b state=%h ok",
                             cyc, latch, pc_inc, dvy_go, state);
                end else begin
                    $display("FAIL dut_strobe: got cyc=%0d latch=%b pc=%b dvy=%b st=%h, required cyc=%0d latch=%b pc=%b dvy=%b st=%h",
                             cyc, latch, pc_inc, dvy_go, state,
                             mon_e.c, mon_e.lt, mon_e.pc, mon_e.dv, mon_e.st);
                end
            end
        end
    end

    // Monitor for dut4 strobes
    always @(negedge clk) begin
        if (latch4 != 4'b0 || pc_inc4 || dvy_go4) begin
            checks++;
            if (sb4.size() == 0) begin
                $display("FAIL dut4_unexpected_strobe: cyc=%0d latch=%b pc_inc=%b dvy_go=%b state=%h, required none",
                         cyc, latch4, pc_inc4, dvy_go4, state4);
            end else begin
                mon_e4 = sb4.pop_front();
                if (mon_e4.c == cyc && mon_e4.lt == latch4 && mon_e4.pc == pc_inc4 &&
                    mon_e4.dv == dvy_go4 && mon_e4.st == state4) begin
                    passes++;
                    $display("dut4 strobe cyc=%0d latch=%b pc_inc=%b dvy_go=%b state=%h ok",
                             cyc, latch4, pc_inc4, dvy_go4, state4);
                end else begin
                    $display("FAIL dut4_strobe: got cyc=%0d latch=%b pc=%b dvy=%b st=%h, required cyc=%0d latch=%b pc=%b dvy=%b st=%h",
                             cyc, latch4, pc_inc4, dvy_go4, state4,
                             mon_e4.c, mon_e4.lt, mon_e4.pc, mon_e4.dv, mon_e4.st);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish within time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int n, m, cs_seen;
        for (int i = 0; i < 256; i++) rom_mem[i] = 4'b1110;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_halt", halt, 1);
        chk("rst_rom_cs", rom_cs, 0);
        chk("rst_state", state, 0);
        chk("rst_strobes", {latch, pc_inc, dvy_go}, 0);
        chk("rst_rom_addr", rom_addr, 0);
        reset = 1'b0;
        @(negedge clk);
        chk("post_rst_halt", halt, 1);
        chk("post_rst_halt4", halt4, 1);

        // pc_inc microstep followed by halt
        dat_op = 4'h0;
        rom_mem[8'h00] = 4'hC;
        rom_mem[8'h0C] = 4'hE;
        n = cyc; go = 1'b1;
        expect_stb(0, n + 3, 4'b0000, 1'b1, 1'b0, 4'hC);
        to_cyc(n + 1); go = 1'b0;
        chk("t1_rom_cs_fetch", rom_cs, 1);
        chk("t1_rom_addr", rom_addr, 8'h00);
        chk("t1_halt_low", halt, 0);
        to_cyc(n + 2); chk("t1_rom_cs_wait", rom_cs, 0);
        to_cyc(n + 3); chk("t1_state_c", state, 4'hC);
        to_cyc(n + 6); chk("t1_exec_halt_low", halt, 0); chk("t1_state_e", state, 4'hE);
        to_cyc(n + 7); chk("t1_halt_rise", halt, 1); chk("t1_addr_hold", rom_addr, 8'h0C);
        cs_seen = 0;
        repeat (5) begin @(negedge clk); if (rom_cs) cs_seen++; end
        chk("t1_no_rom_cs_after_halt", cs_seen, 0);

        // Latch strobes, a no-strobe step, a NOP step, then halt
        dat_op = 4'h3;
        rom_mem[8'h30] = 4'h8; rom_mem[8'h38] = 4'h9; rom_mem[8'h39] = 4'hA;
        rom_mem[8'h3A] = 4'hB; rom_mem[8'h3B] = 4'h5; rom_mem[8'h35] = 4'hF;
        rom_mem[8'h3F] = 4'hE;
        n = cyc; go = 1'b1;
        expect_stb(0, n + 3,  4'b0001, 1'b0, 1'b0, 4'h8);
        expect_stb(0, n + 6,  4'b0010, 1'b0, 1'b0, 4'h9);
        expect_stb(0, n + 9,  4'b0100, 1'b0, 1'b0, 4'hA);
        expect_stb(0, n + 12, 4'b1000, 1'b0, 1'b0, 4'hB);
        to_cyc(n + 1); go = 1'b0;
        to_cyc(n + 15); chk("t2_state_5", state, 4'h5);
        to_cyc(n + 18); chk("t2_state_f", state, 4'hF);
        to_cyc(n + 21); chk("t2_halt_low", halt, 0);
        to_cyc(n + 22); chk("t2_halt_rise", halt, 1);

        // dvy_go then timer wait; timer_done in the EXEC cycle is ignored
        dat_op = 4'h1;
        rom_mem[8'h10] = 4'hD; rom_mem[8'h1D] = 4'hE;
        n = cyc; go = 1'b1;
        expect_stb(0, n + 3, 4'b0000, 1'b0, 1'b1, 4'hD);
        to_cyc(n + 1); go = 1'b0;
        to_cyc(n + 3); timer_done = 1'b1;
        cs_seen = 0;
        for (int k = n + 4; k <= n + 13; k++) begin
            to_cyc(k);
            timer_done = 1'b0;
            if (rom_cs) cs_seen++;
        end
        chk("t3_no_rom_cs_in_twait", cs_seen, 0);
        chk("t3_state_twait", state, 4'hD);
        timer_done = 1'b1;
        to_cyc(n + 14); timer_done = 1'b0;
        chk("t3_rom_cs_after_timer", rom_cs, 1);
        chk("t3_rom_addr", rom_addr, 8'h1D);
        to_cyc(n + 17); chk("t3_halt_rise", halt, 1);

        // go while running is ignored; vgrst+go aborts; go alone restarts
        dat_op = 4'h2;
        rom_mem[8'h20] = 4'hC; rom_mem[8'h2C] = 4'hC;
        n = cyc; go = 1'b1;
        expect_stb(0, n + 3, 4'b0000, 1'b1, 1'b0, 4'hC);
        expect_stb(0, n + 6, 4'b0000, 1'b1, 1'b0, 4'hC);
        to_cyc(n + 1); go = 1'b0;
        to_cyc(n + 5); go = 1'b1;
        to_cyc(n + 6); go = 1'b0;
        to_cyc(n + 8); vgrst = 1'b1; go = 1'b1;
        to_cyc(n + 9); vgrst = 1'b0; go = 1'b0;
        chk("t4_vgrst_halt", halt, 1);
        chk("t4_vgrst_state", state, 0);
        chk("t4_vgrst_rom_cs", rom_cs, 0);
        to_cyc(n + 12);
        m = cyc; go = 1'b1;
        expect_stb(0, m + 3, 4'b0000, 1'b1, 1'b0, 4'hC);
        to_cyc(m + 1); go = 1'b0;
        chk("t4_restart_rom_cs", rom_cs, 1);
        chk("t4_restart_addr", rom_addr, 8'h20);
        to_cyc(m + 4); vgrst = 1'b1;
        to_cyc(m + 5); vgrst = 1'b0;
        chk("t4_stop_halt", halt, 1);

        // Hard reset in the middle of a microstep
        n = cyc; go = 1'b1;
        expect_stb(0, n + 3, 4'b0000, 1'b1, 1'b0, 4'hC);
        to_cyc(n + 1); go = 1'b0;
        to_cyc(n + 5); reset = 1'b1; #1;
        chk("t5_rst_state", state, 0);
        chk("t5_rst_halt", halt, 1);
        chk("t5_rst_rom_cs", rom_cs, 0);
        to_cyc(n + 6); reset = 1'b0;
        to_cyc(n + 7); chk("t5_post_rst_halt", halt, 1);
        to_cyc(n + 9); chk("t5_post_rst_state", state, 0);

        // Timer never expires: watchdog abort or indefinite wait
        dat_op = 4'h4;
        rom_mem[8'h40] = 4'hD; rom_mem[8'h4D] = 4'hE;
        n = cyc; go = 1'b1;
        expect_stb(0, n + 3, 4'b0000, 1'b0, 1'b1, 4'hD);
        to_cyc(n + 1); go = 1'b0;
`ifdef VG_WATCHDOG_EN
        to_cyc(n + 19); chk("t6_wdog_halt_low", halt, 0); chk("t6_wdog_state_d", state, 4'hD);
        to_cyc(n + 20); chk("t6_wdog_halt", halt, 1); chk("t6_wdog_state_0", state, 0);
        chk("t6_wdog_rom_cs", rom_cs, 0);
`else
        to_cyc(n + 40); chk("t6_twait_halt_low", halt, 0); chk("t6_twait_state_d", state, 4'hD);
        vgrst = 1'b1;
        to_cyc(n + 41); vgrst = 1'b0;
        chk("t6_vgrst_halt", halt, 1);
`endif

        // STEP_DIV=4: chain of pc_inc steps every 6 cycles
        to_cyc(cyc + 2);
        dat_op = 4'h6;
        rom_mem[8'h60] = 4'hC; rom_mem[8'h6C] = 4'hC;
        n = cyc; go4 = 1'b1;
        expect_stb(1, n + 3,  4'b0000, 1'b1, 1'b0, 4'hC);
        expect_stb(1, n + 9,  4'b0000, 1'b1, 1'b0, 4'hC);
        expect_stb(1, n + 15, 4'b0000, 1'b1, 1'b0, 4'hC);
        expect_stb(1, n + 21, 4'b0000, 1'b1, 1'b0, 4'hC);
        to_cyc(n + 1); go4 = 1'b0;
        chk("t7_rom_cs4_first", rom_cs4, 1);
        to_cyc(n + 6); chk("t7_rom_cs4_pace", rom_cs4, 0);
        to_cyc(n + 7); chk("t7_rom_cs4_second", rom_cs4, 1);
        to_cyc(n + 22); vgrst4 = 1'b1;
        to_cyc(n + 23); vgrst4 = 1'b0;
        chk("t7_halt4", halt4, 1);

        repeat (4) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("sb4_empty", sb4.size(), 0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/vg_state_seq.md
VG_STATE_SEQ -- requirements
Module: vg_state_seq

Interface
REQ-001 Parameter STEP_DIV, default 1, idle cycles inserted between microsteps (1..255).
REQ-002 Parameter WDOG_CYCLES, default 4096, TWAIT watchdog limit (used only with VG_WATCHDOG_EN).
REQ-003 clk  in  1  single system clock; all logic on posedge.
REQ-004 reset  in  1  asynchronous, active-high reset.
REQ-005 go  in  1  CPU vector-go strobe, one-cycle pulse.
REQ-006 vgrst  in  1  CPU vector soft-reset strobe, one-cycle pulse.
REQ-007 dat_op  in  4  opcode nibble from vector data latch.
REQ-008 timer_done  in  1  DVY/timer expired level.
REQ-009 rom_addr  out  8  state PROM address, {op[3:0], state[3:0]}.
REQ-010 rom_cs  out  1  state PROM select; high only in FETCH.
REQ-011 rom_dout  in  4  state PROM data; registered, valid one cycle after address.
REQ-012 latch  out  4  one-hot data-latch strobes latch[0..3].
REQ-013 pc_inc  out  1  vector PC increment strobe.
REQ-014 dvy_go  out  1  timer start strobe.
REQ-015 halt  out  1  generator halted level.
REQ-016 state  out  4  current microstate (debug).

Function
REQ-017 FSM states: IDLE, FETCH, WAIT, EXEC, TWAIT, PACE.
REQ-018 IDLE: halt=1; go -> state<=0, FETCH next cycle.
REQ-019 FETCH: op<=dat_op, rom_addr={dat_op,state}, rom_cs=1; -> WAIT.
REQ-020 WAIT: state<=rom_dout at cycle end; -> EXEC.
REQ-021 EXEC: if state[3]=1 exactly one strobe pulses one cycle by index state[2:0]: 0-3 latch[n], 4 pc_inc, 5 dvy_go, 6 halt-set, 7 none; state[3]=0 -> no strobe.
REQ-022 EXEC exit priority: halt-set -> IDLE; dvy_go -> TWAIT; STEP_DIV>1 -> PACE; else FETCH.
REQ-023 TWAIT: leave to PACE/FETCH on first cycle timer_done=1; timer_done in EXEC cycle of dvy_go is ignored.
REQ-024 PACE: 8-bit counter counts STEP_DIV-1 cycles then -> FETCH; microstep period = 3+(STEP_DIV-1) cycles.
REQ-025 go while not IDLE is ignored.
REQ-026 vgrst in any state: next cycle IDLE, state=0, strobes 0; vgrst wins over simultaneous go.
REQ-027 Latency: go at cycle N -> rom_cs at N+1, state update end of N+2, strobe at N+3.
REQ-028 rom_addr holds its last value outside FETCH; strobes are registered, glitch-free.

Reset
REQ-029 On reset: FSM=IDLE, state=0, op=0, halt=1, rom_cs=0, latch=0, pc_inc=0, dvy_go=0, pace/watchdog counters=0.
REQ-030 Reset mid-microstep abandons it; no strobe is emitted during or in the cycle after reset release.

Configuration
REQ-031 Macro VG_WATCHDOG_EN defined: 16-bit counter in TWAIT; reaching WDOG_CYCLES -> IDLE, halt=1, state=0.
REQ-032 VG_WATCHDOG_EN undefined: no counter; TWAIT waits on timer_done indefinitely.

Structure
REQ-033 Package vg_pkg holds FSM state encoding, strobe index constants (STB_LATCH0..STB_NOP), ROM address/data widths.
REQ-034 Sub-module vg_step_pacer holds the PACE counter (load, count, done); watchdog stays inline under the macro.

Verification
REQ-035 PROM model: addr 0x00 returns 4'b1100; go with dat_op=0 -> pc_inc pulses at go+3 cycles, state=4'hC.
REQ-036 PROM entry 4'b1110 -> halt rises the cycle after EXEC, FSM IDLE, no further rom_cs.
REQ-037 Entry 4'b1101, timer_done asserted 10 cycles later -> dvy_go once, rom_cs next at timer_done+1 cycle.
REQ-038 vgrst and go same cycle while running -> IDLE, halt=1, no strobe; go alone later restarts at state 0.
REQ-039 STEP_DIV=4, chain of 1100 entries -> pc_inc every 6 cycles exactly.
REQ-040 VG_WATCHDOG_EN, WDOG_CYCLES=16, timer_done held 0 -> halt=1 after 16 TWAIT cycles; undefined -> stays TWAIT.
